// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// Module   : i2c_req_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one I2C transaction engine
//            among N_REQ on-chip requesters. Grants one requester at a time,
//            launches its command on the engine, waits for completion or a
//            watchdog expiry, and returns status/read data with a done pulse.
// Ports    :
//   i2c_clk, rst_n          clock, synchronous active-low reset
//   req/req_addr/req_rw/
//   req_wdata               per-requester request level and packed fields
//   gnt, done               one-hot grant, one-cycle completion pulse
//   rdata, ack_err, timeout status of the last completed transaction
//   busy                    high whenever the sequencer is not idle
//   eng_start/eng_abort/
//   eng_addr/eng_rw/
//   eng_wdata               registered command interface to the engine
//   eng_busy/eng_done/
//   eng_nack/eng_rdata      engine status inputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_req_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int PTR_W       = $clog2(N_REQ)
) (
    input  logic                 i2c_clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [7*N_REQ-1:0]   req_addr,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           rdata,
    output logic                 ack_err,
    output logic                 timeout,
    output logic                 busy,
    output logic                 eng_start,
    output logic                 eng_abort,
    output logic [6:0]           eng_addr,
    output logic                 eng_rw,
    output logic [7:0]           eng_wdata,
    input  logic                 eng_busy,
    input  logic                 eng_done,
    input  logic                 eng_nack,
    input  logic [7:0]           eng_rdata
);

    localparam int                 c_tmr_w    = $clog2(TIMEOUT_CYC);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0]   c_idx_last = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_idx;
    logic [c_tmr_w-1:0]   r_timer;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     r_done;
    logic [7:0]           r_rdata;
    logic                 r_ack_err;
    logic                 r_timeout;
    logic                 r_eng_start;
    logic                 r_eng_abort;
    logic [6:0]           r_eng_addr;
    logic                 r_eng_rw;
    logic [7:0]           r_eng_wdata;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [PTR_W-1:0]     w_idx_nxt;
    logic [c_tmr_w-1:0]   w_timer_nxt;
    logic [N_REQ-1:0]     w_gnt_nxt;
    logic [N_REQ-1:0]     w_done_nxt;
    logic [7:0]           w_rdata_nxt;
    logic                 w_ack_err_nxt;
    logic                 w_timeout_nxt;
    logic                 w_eng_start_nxt;
    logic                 w_eng_abort_nxt;
    logic [6:0]           w_eng_addr_nxt;
    logic                 w_eng_rw_nxt;
    logic [7:0]           w_eng_wdata_nxt;

    // ------------------------------------------------------------------
    // Round-robin winner search.
    // w_rot[i] is req[(ptr + i) mod N_REQ]; the lowest set bit of w_rot is
    // the offset of the winner from ptr. Scanning downward lets the lowest
    // match be the last assignment, so no loop break is needed.
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]     w_rot;
    logic                 w_any;
    logic [PTR_W-1:0]     w_win;
    int                   w_off;
    int                   w_sum;

    always_comb begin
        w_rot = N_REQ'({req, req} >> r_ptr);
        w_any = 1'b0;
        w_off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                w_off = i;
            end
        end
        w_sum = int'(r_ptr) + w_off;
        if (w_sum >= N_REQ) begin
            w_sum = w_sum - N_REQ;
        end
        w_win = PTR_W'(w_sum);
    end

    // ------------------------------------------------------------------
    // Command fields of the granted requester
    // ------------------------------------------------------------------
    logic [6:0]           w_sel_addr;
    logic                 w_sel_rw;
    logic [7:0]           w_sel_wdata;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_rw    = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_idx == PTR_W'(i)) begin
                w_sel_addr  = req_addr[7*i +: 7];
                w_sel_rw    = req_rw[i];
                w_sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_idx_nxt       = r_idx;
        w_timer_nxt     = r_timer;
        w_gnt_nxt       = r_gnt;
        w_done_nxt      = '0;
        w_rdata_nxt     = r_rdata;
        w_ack_err_nxt   = r_ack_err;
        w_timeout_nxt   = r_timeout;
        w_eng_start_nxt = 1'b0;
        w_eng_abort_nxt = 1'b0;
        w_eng_addr_nxt  = r_eng_addr;
        w_eng_rw_nxt    = r_eng_rw;
        w_eng_wdata_nxt = r_eng_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_idx_nxt   = w_win;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_state_nxt = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                if (!eng_busy) begin
                    w_eng_addr_nxt  = w_sel_addr;
                    w_eng_rw_nxt    = w_sel_rw;
                    w_eng_wdata_nxt = w_sel_wdata;
                    w_eng_start_nxt = 1'b1;
                    w_timer_nxt     = '0;
                    w_state_nxt     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                w_timer_nxt = r_timer + c_tmr_w'(1);
                // A completion arriving on the expiry cycle is honoured.
                if (eng_done) begin
                    w_rdata_nxt   = eng_rdata;
                    w_ack_err_nxt = eng_nack;
                    w_timeout_nxt = 1'b0;
                    w_done_nxt    = N_REQ'(1) << r_idx;
                    w_state_nxt   = ST_RELEASE;
                end else if (r_timer == c_tmr_last) begin
                    w_eng_abort_nxt = 1'b1;
                    w_timeout_nxt   = 1'b1;
                    w_ack_err_nxt   = 1'b0;
                    w_done_nxt      = N_REQ'(1) << r_idx;
                    w_state_nxt     = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                w_gnt_nxt   = '0;
                w_ptr_nxt   = (r_idx == c_idx_last) ? '0 : r_idx + PTR_W'(1);
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register. The engine shares this reset, so an in-flight
    // transaction is simply dropped without an abort pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge i2c_clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_ack_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_abort <= 1'b0;
            r_eng_addr  <= '0;
            r_eng_rw    <= 1'b0;
            r_eng_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_idx       <= w_idx_nxt;
            r_timer     <= w_timer_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ack_err   <= w_ack_err_nxt;
            r_timeout   <= w_timeout_nxt;
            r_eng_start <= w_eng_start_nxt;
            r_eng_abort <= w_eng_abort_nxt;
            r_eng_addr  <= w_eng_addr_nxt;
            r_eng_rw    <= w_eng_rw_nxt;
            r_eng_wdata <= w_eng_wdata_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign ack_err   = r_ack_err;
    assign timeout   = r_timeout;
    assign busy      = (r_state != ST_IDLE);
    assign eng_start = r_eng_start;
    assign eng_abort = r_eng_abort;
    assign eng_addr  = r_eng_addr;
    assign eng_rw    = r_eng_rw;
    assign eng_wdata = r_eng_wdata;

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Purpose  : Self-checking bench for i2c_req_arbiter. Directed requests push
//            expected command fields and completion results into queues; an
//            engine model pops commands on eng_start, and a monitor pops
//            results whenever a done pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_req_arbiter;

    localparam int N_REQ       = 2;
    localparam int TIMEOUT_CYC = 16;

    logic               i2c_clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req;
    logic [7*N_REQ-1:0] req_addr;
    logic [N_REQ-1:0]   req_rw;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   done;
    logic [7:0]         rdata;
    logic               ack_err;
    logic               timeout;
    logic               busy;
    logic               eng_start;
    logic               eng_abort;
    logic [6:0]         eng_addr;
    logic               eng_rw;
    logic [7:0]         eng_wdata;
    logic               eng_busy;
    logic               eng_done;
    logic               eng_nack;
    logic [7:0]         eng_rdata;

    i2c_req_arbiter #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i2c_clk   (i2c_clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .ack_err   (ack_err),
        .timeout   (timeout),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_abort (eng_abort),
        .eng_addr  (eng_addr),
        .eng_rw    (eng_rw),
        .eng_wdata (eng_wdata),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done),
        .eng_nack  (eng_nack),
        .eng_rdata (eng_rdata)
    );

    always #5 i2c_clk = ~i2c_clk;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic       ack;
        logic       to;
        int         lat;
    } exp_t;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } cmd_t;

    exp_t exp_q[$];
    cmd_t cmd_q[$];

    int checks  = 0;
    int errors  = 0;
    int n_done  = 0;
    int n_start = 0;
    int cyc     = 0;
    int start_cyc = 0;
    logic busy_s = 1'b0;

    // Engine behaviour for the next launch
    int         cfg_delay = 0;
    logic       cfg_hang  = 1'b0;
    logic       cfg_nack  = 1'b0;
    logic [7:0] cfg_rdata = 8'h00;

    logic [32:0] outs;
    assign outs = {gnt, done, rdata, ack_err, timeout, busy, eng_start,
                   eng_abort, eng_addr, eng_rw, eng_wdata};

    always @(posedge i2c_clk) cyc    <= cyc + 1;
    always @(posedge i2c_clk) busy_s <= eng_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i2c_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        req_addr[7*i +: 7]  = a;
        req_rw[i]           = rw;
        req_wdata[8*i +: 8] = wd;
    endtask

    task automatic expect_txn(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                              input logic [7:0] rd, input logic ack, input logic to, input int lat);
        cmd_t c;
        exp_t e;
        c.addr = a; c.rw = rw; c.wdata = wd;
        e.idx = i; e.rdata = rd; e.ack = ack; e.to = to; e.lat = lat;
        cmd_q.push_back(c);
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        chk("wait_done", 64'(n_done), 64'(target));
    endtask

    // Engine model: checks the launched command, then answers after
    // cfg_delay cycles unless told to hang.
    initial begin
        cmd_t c;
        eng_done  = 1'b0;
        eng_nack  = 1'b0;
        eng_rdata = 8'h00;
        forever begin
            @(negedge i2c_clk);
            if (eng_start) begin
                n_start++;
                start_cyc = cyc;
                chk("start_while_busy", 64'(busy_s), 64'd0);
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=1 required=0");
                end else begin
                    c = cmd_q.pop_front();
                    chk("eng_addr", 64'(eng_addr), 64'(c.addr));
                    chk("eng_rw", 64'(eng_rw), 64'(c.rw));
                    chk("eng_wdata", 64'(eng_wdata), 64'(c.wdata));
                end
                if (!cfg_hang) begin
                    repeat (cfg_delay) @(negedge i2c_clk);
                    eng_done  = 1'b1;
                    eng_nack  = cfg_nack;
                    eng_rdata = cfg_rdata;
                    @(negedge i2c_clk);
                    eng_done  = 1'b0;
                    eng_nack  = 1'b0;
                    eng_rdata = 8'h00;
                end
            end
        end
    end

    // Monitor: pops the expected result on every done pulse.
    initial begin
        exp_t e;
        logic after_done;
        logic prev_start;
        after_done = 1'b0;
        prev_start = 1'b0;
        forever begin
            @(negedge i2c_clk);
            if (rst_n === 1'b1) begin
                chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
                if (prev_start) chk("start_one_cycle", 64'(eng_start), 64'd0);
                if (after_done) begin
                    chk("gnt_drop", 64'(gnt), 64'd0);
                    chk("done_one_cycle", 64'(done), 64'd0);
                    chk("abort_one_cycle", 64'(eng_abort), 64'd0);
                    after_done = 1'b0;
                end
                if (done != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual=%b required=00", done);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_idx", 64'(done), 64'd1 << e.idx);
                        chk("gnt_at_done", 64'(gnt), 64'd1 << e.idx);
                        chk("rdata", 64'(rdata), 64'(e.rdata));
                        chk("ack_err", 64'(ack_err), 64'(e.ack));
                        chk("timeout", 64'(timeout), 64'(e.to));
                        chk("eng_abort", 64'(eng_abort), 64'(e.to));
                        chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
                    end
                    n_done++;
                    after_done = 1'b1;
                end else if (eng_abort) begin
                    checks++;
                    errors++;
                    $display("FAIL abort_without_done actual=1 required=0");
                end
                prev_start = eng_start;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        int s0;
        int k;
        rst_n     = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_rw    = '0;
        req_wdata = '0;
        eng_busy  = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 64'(outs), 64'd0);
        rst_n = 1'b1;

        // Single write, requester 0
        cfg_delay = 11; cfg_nack = 1'b0; cfg_rdata = 8'h00;
        set_req(0, 7'h78, 1'b0, 8'hA5);
        expect_txn(0, 7'h78, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 12);
        req = 2'b01;
        wait_done(1, 100);
        req = 2'b00;

        // Read with NACK, requester 1
        cfg_delay = 6; cfg_nack = 1'b1; cfg_rdata = 8'h3C;
        set_req(1, 7'h7F, 1'b1, 8'h00);
        expect_txn(1, 7'h7F, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b0, 7);
        req = 2'b10;
        wait_done(2, 100);
        req = 2'b00;

        // Contention: both held, grants must alternate 0,1,0,1
        cfg_delay = 3; cfg_nack = 1'b0; cfg_rdata = 8'h55;
        set_req(0, 7'h12, 1'b0, 8'h11);
        set_req(1, 7'h34, 1'b0, 8'h22);
        expect_txn(0, 7'h12, 1'b0, 8'h11, 8'h55, 1'b0, 1'b0, 4);
        expect_txn(1, 7'h34, 1'b0, 8'h22, 8'h55, 1'b0, 1'b0, 4);
        expect_txn(0, 7'h12, 1'b0, 8'h11, 8'h55, 1'b0, 1'b0, 4);
        expect_txn(1, 7'h34, 1'b0, 8'h22, 8'h55, 1'b0, 1'b0, 4);
        req = 2'b11;
        wait_done(6, 200);
        req = 2'b00;

        // Watchdog: engine never answers; rdata keeps 0x55
        cfg_hang = 1'b1;
        set_req(0, 7'h50, 1'b0, 8'h66);
        expect_txn(0, 7'h50, 1'b0, 8'h66, 8'h55, 1'b0, 1'b1, TIMEOUT_CYC);
        req = 2'b01;
        wait_done(7, 100);
        req = 2'b00;
        cfg_hang = 1'b0;

        // Normal completion afterwards clears timeout
        cfg_delay = 5; cfg_nack = 1'b0; cfg_rdata = 8'h9A;
        set_req(1, 7'h21, 1'b1, 8'h00);
        expect_txn(1, 7'h21, 1'b1, 8'h00, 8'h9A, 1'b0, 1'b0, 6);
        req = 2'b10;
        wait_done(8, 100);
        req = 2'b00;

        // Engine busy at launch for 10 cycles
        eng_busy = 1'b1;
        cfg_delay = 2; cfg_nack = 1'b0; cfg_rdata = 8'h77;
        set_req(0, 7'h2A, 1'b0, 8'hB4);
        expect_txn(0, 7'h2A, 1'b0, 8'hB4, 8'h77, 1'b0, 1'b0, 3);
        s0 = n_start;
        req = 2'b01;
        repeat (10) tick();
        chk("busy_hold_no_start", 64'(n_start), 64'(s0));
        chk("busy_hold_gnt", 64'(gnt), 64'd1);
        chk("busy_hold_busy", 64'(busy), 64'd1);
        eng_busy = 1'b0;
        wait_done(9, 100);
        req = 2'b00;

        // eng_done on the expiry cycle: completion wins, no abort
        cfg_delay = TIMEOUT_CYC - 1; cfg_nack = 1'b0; cfg_rdata = 8'hC3;
        set_req(1, 7'h11, 1'b0, 8'h5A);
        expect_txn(1, 7'h11, 1'b0, 8'h5A, 8'hC3, 1'b0, 1'b0, TIMEOUT_CYC);
        req = 2'b10;
        wait_done(10, 100);
        req = 2'b00;

        // Move the pointer to 1, then reset during WAIT
        cfg_delay = 1; cfg_nack = 1'b0; cfg_rdata = 8'h01;
        set_req(0, 7'h0F, 1'b1, 8'h00);
        expect_txn(0, 7'h0F, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 2);
        req = 2'b01;
        wait_done(11, 100);
        req = 2'b00;

        cfg_hang = 1'b1;
        set_req(1, 7'h44, 1'b1, 8'h00);
        begin
            cmd_t c;
            c.addr = 7'h44; c.rw = 1'b1; c.wdata = 8'h00;
            cmd_q.push_back(c);
        end
        s0 = n_start;
        req = 2'b10;
        k = 0;
        while (n_start == s0 && k < 20) begin
            tick();
            k++;
        end
        chk("reset_launch_seen", 64'(n_start), 64'(s0 + 1));
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("midwait_reset_outputs", 64'(outs), 64'd0);
        rst_n = 1'b1;
        cfg_hang = 1'b0;
        cfg_delay = 4; cfg_nack = 1'b0; cfg_rdata = 8'hE1;
        set_req(0, 7'h33, 1'b0, 8'h99);
        // Pointer restarts at 0, so requester 0 wins first
        expect_txn(0, 7'h33, 1'b0, 8'h99, 8'hE1, 1'b0, 1'b0, 5);
        expect_txn(1, 7'h44, 1'b1, 8'h00, 8'hE1, 1'b0, 1'b0, 5);
        req = 2'b11;
        wait_done(12, 100);
        req[0] = 1'b0;
        wait_done(13, 100);
        req = 2'b00;

        repeat (5) tick();
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
